// File: rtl/pc_seq_ctrl_if.sv
// Handshake bundle between the PC sequencing controller (master) and the
// datapath/memory side (slave): decoded instruction fields in, strobes out.
interface pc_seq_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       br_eq;
    logic       br_lt;
    logic       br_ltu;
    logic       is_mret;
    logic       imem_ack;
    logic       intr;
    logic       mie;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       ir_write;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       rf_we;
    logic       int_taken;
    logic       mret_exec;

    modport master (
        input  opcode, func3, br_eq, br_lt, br_ltu, is_mret, imem_ack, intr, mie,
        output pc_source, pc_write, ir_write, mem_rden1, mem_rden2, mem_we2, rf_we,
               int_taken, mret_exec
    );

    modport slave (
        output opcode, func3, br_eq, br_lt, br_ltu, is_mret, imem_ack, intr, mie,
        input  pc_source, pc_write, ir_write, mem_rden1, mem_rden2, mem_we2, rf_we,
               int_taken, mret_exec
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle RV32 PC sequencer: FETCH -> EXEC [-> WRITEBACK] [-> INTR].
// Define PC_SEQ_INTR_EN to add the interrupt/MRET path (INTR state, intr_pend).
module pc_seq_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    pc_seq_ctrl_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] PCS_SEQ  = 3'd0;
    localparam logic [2:0] PCS_JALR = 3'd1;
    localparam logic [2:0] PCS_BR   = 3'd2;
    localparam logic [2:0] PCS_JAL  = 3'd3;
`ifdef PC_SEQ_INTR_EN
    localparam logic [2:0] PCS_TRAP = 3'd4;
    localparam logic [2:0] PCS_MRET = 3'd5;
`endif

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WRITEBACK
`ifdef PC_SEQ_INTR_EN
        , INTR
`endif
    } state_e;

    state_e     state_q, state_d;
    logic       br_cond, br_taken;
    logic [2:0] pc_source;
    logic       pc_write, ir_write, mem_rden1, mem_rden2, mem_we2, rf_we;
    logic       int_taken, mret_exec;

`ifdef PC_SEQ_INTR_EN
    logic intr_pend_q, intr_pend_d;
    logic intr_go;
    // A same-cycle request counts as pending so a pulse on the last EXEC cycle is not lost.
    assign intr_go = intr_pend_q | (bus.intr & bus.mie);
`else
    logic unused_intr;
    assign unused_intr = ^{bus.intr, bus.mie, bus.is_mret};
`endif

    // func3[2:1] picks the flag, func3[0] inverts it; 01x encodings never branch.
    always_comb begin
        br_cond = 1'b0;
        case (bus.func3[2:1])
            2'b00:   br_cond = bus.br_eq;
            2'b10:   br_cond = bus.br_lt;
            2'b11:   br_cond = bus.br_ltu;
            default: br_cond = 1'b0;
        endcase
        br_taken = (bus.func3[2:1] != 2'b01) & (br_cond ^ bus.func3[0]);
    end

    always_comb begin
        state_d   = state_q;
        pc_source = PCS_SEQ;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        rf_we     = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
`ifdef PC_SEQ_INTR_EN
        intr_pend_d = intr_go;
`endif
        case (state_q)
            FETCH: begin
                mem_rden1 = 1'b1;
                if (bus.imem_ack) begin
                    ir_write = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                pc_write = 1'b1;
                state_d  = FETCH;
`ifdef PC_SEQ_INTR_EN
                if (intr_go) state_d = INTR;
                // MRET returns to the interrupted stream first; the pending trap waits one instruction.
                if (bus.is_mret) begin
                    pc_source = PCS_MRET;
                    mret_exec = 1'b1;
                    state_d   = FETCH;
                end else begin
`else
                begin
`endif
                    case (bus.opcode)
                        OP_JAL: begin
                            pc_source = PCS_JAL;
                            rf_we     = 1'b1;
                        end
                        OP_JALR: begin
                            pc_source = PCS_JALR;
                            rf_we     = 1'b1;
                        end
                        OP_BRANCH: pc_source = br_taken ? PCS_BR : PCS_SEQ;
                        OP_LOAD: begin
                            mem_rden2 = 1'b1;
                            state_d   = WRITEBACK;
                        end
                        OP_STORE: mem_we2 = 1'b1;
                        OP_REG, OP_IMM, OP_LUI, OP_AUIPC: rf_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            WRITEBACK: begin
                rf_we   = 1'b1;
                state_d = FETCH;
`ifdef PC_SEQ_INTR_EN
                if (intr_go) state_d = INTR;
`endif
            end
`ifdef PC_SEQ_INTR_EN
            INTR: begin
                pc_source   = PCS_TRAP;
                pc_write    = 1'b1;
                int_taken   = 1'b1;
                intr_pend_d = 1'b0;
                state_d     = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
        if (!rst_n) begin
            pc_source = PCS_SEQ;
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_rden1 = 1'b0;
            mem_rden2 = 1'b0;
            mem_we2   = 1'b0;
            rf_we     = 1'b0;
            int_taken = 1'b0;
            mret_exec = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH;
`ifdef PC_SEQ_INTR_EN
            intr_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
`ifdef PC_SEQ_INTR_EN
            intr_pend_q <= intr_pend_d;
`endif
        end
    end

    assign bus.pc_source = pc_source;
    assign bus.pc_write  = pc_write;
    assign bus.ir_write  = ir_write;
    assign bus.mem_rden1 = mem_rden1;
    assign bus.mem_rden2 = mem_rden2;
    assign bus.mem_we2   = mem_we2;
    assign bus.rf_we     = rf_we;
    assign bus.int_taken = int_taken;
    assign bus.mret_exec = mret_exec;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model; works with or without PC_SEQ_INTR_EN.
module tb_pc_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    pc_seq_ctrl_if bus ();
    pc_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

`ifdef PC_SEQ_INTR_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [6:0] t_op;
    logic [2:0] t_f3;
    bit t_eq, t_lt, t_ltu, t_mret, t_ack, t_intr, t_mie, t_rst;

    // Model phase: 0 fetch, 1 execute, 2 load writeback, 3 trap entry
    int m_ph = 0;
    bit m_pend = 1'b0;
    logic [10:0] obs, exp_v;

    // {pc_source[2:0], pc_write, ir_write, mem_rden1, mem_rden2, mem_we2, rf_we, int_taken, mret_exec}
    function automatic logic [10:0] pack(logic [2:0] ps, bit pw, bit irw, bit r1, bit r2,
                                         bit we2, bit rfwe, bit it, bit me);
        return {ps, pw, irw, r1, r2, we2, rfwe, it, me};
    endfunction

    function automatic bit taken(logic [2:0] f3, bit eq, bit lt, bit ltu);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [10:0] model_out();
        logic [2:0] ps = 3'd0;
        bit pw = 0, irw = 0, r1 = 0, r2 = 0, we2 = 0, rfwe = 0, it = 0, me = 0;
        if (t_rst) begin
            case (m_ph)
                0: begin r1 = 1; irw = t_ack; end
                1: begin
                    pw = 1;
                    if (INT_EN && t_mret) begin ps = 3'd5; me = 1; end
                    else case (t_op)
                        7'b1101111: begin ps = 3'd3; rfwe = 1; end
                        7'b1100111: begin ps = 3'd1; rfwe = 1; end
                        7'b1100011: ps = taken(t_f3, t_eq, t_lt, t_ltu) ? 3'd2 : 3'd0;
                        7'b0000011: r2 = 1;
                        7'b0100011: we2 = 1;
                        7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: rfwe = 1;
                        default: ;
                    endcase
                end
                2: rfwe = 1;
                3: begin ps = 3'd4; pw = 1; it = 1; end
                default: ;
            endcase
        end
        return pack(ps, pw, irw, r1, r2, we2, rfwe, it, me);
    endfunction

    task automatic defaults();
        t_op = 7'b0010011; t_f3 = 3'd0; t_eq = 0; t_lt = 0; t_ltu = 0;
        t_mret = 0; t_ack = 0; t_intr = 0; t_mie = 0; t_rst = 1;
    endtask

    // One clock: drive, sample at negedge, advance the model on the posedge.
    task automatic step();
        int nph;
        bit np, want_int;
        bus.opcode = t_op; bus.func3 = t_f3; bus.br_eq = t_eq; bus.br_lt = t_lt;
        bus.br_ltu = t_ltu; bus.is_mret = t_mret; bus.imem_ack = t_ack;
        bus.intr = t_intr; bus.mie = t_mie; rst_n = t_rst;
        @(negedge clk);
        obs = {bus.pc_source, bus.pc_write, bus.ir_write, bus.mem_rden1, bus.mem_rden2,
               bus.mem_we2, bus.rf_we, bus.int_taken, bus.mret_exec};
        exp_v = model_out();
        want_int = INT_EN && (m_pend || (t_intr && t_mie));
        nph = 0;
        np = 0;
        if (t_rst) begin
            np = INT_EN && (m_ph != 3) && (m_pend || (t_intr && t_mie));
            case (m_ph)
                0: nph = t_ack ? 1 : 0;
                1: nph = (INT_EN && t_mret) ? 0 : (t_op == 7'b0000011) ? 2 : want_int ? 3 : 0;
                2: nph = want_int ? 3 : 0;
                default: nph = 0;
            endcase
        end
        @(posedge clk);
        m_ph = nph;
        m_pend = np;
        #1;
    endtask

    function automatic logic [10:0] v_fetch(bit ack);
        return pack(3'd0, 0, ack, 1, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [10:0] v_alu();
        return pack(3'd0, 1, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    function automatic logic [10:0] v_trap_or_fetch();
        return INT_EN ? pack(3'd4, 1, 0, 0, 0, 0, 0, 1, 0) : v_fetch(0);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            defaults();
            t_rst = 0; t_ack = 1; t_intr = 1; t_mie = 1; t_op = 7'b1101111;
            step();
            checks++;
            if (obs !== 11'd0) begin
                failures++;
                $display("FAIL reset c%0d got=%h want=%h", i, obs, 11'd0);
            end
        end
    endtask

    task automatic test_fetch_stall();
        logic [10:0] want;
        for (int i = 0; i < 6; i++) begin
            defaults();
            case (i)
                3: begin t_ack = 1; want = v_fetch(1); end
                4: want = v_alu();
                default: want = v_fetch(0);
            endcase
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL fetch_stall c%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_decode();
        logic [6:0] ops[5];
        logic [10:0] wants[5];
        logic [10:0] want;
        ops[0] = 7'b1101111; wants[0] = pack(3'd3, 1, 0, 0, 0, 0, 1, 0, 0);
        ops[1] = 7'b1100111; wants[1] = pack(3'd1, 1, 0, 0, 0, 0, 1, 0, 0);
        ops[2] = 7'b0100011; wants[2] = pack(3'd0, 1, 0, 0, 0, 1, 0, 0, 0);
        ops[3] = 7'b0110111; wants[3] = pack(3'd0, 1, 0, 0, 0, 0, 1, 0, 0);
        ops[4] = 7'b1111111; wants[4] = pack(3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            defaults();
            if (i % 2 == 0) begin t_ack = 1; want = v_fetch(1); end
            else begin t_op = ops[i/2]; want = wants[i/2]; end
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL decode c%0d op=%b got=%h want=%h", i, t_op, obs, want);
            end
        end
    endtask

    task automatic test_branch();
        logic [10:0] want;
        for (int i = 0; i < 5; i++) begin
            defaults();
            t_op = 7'b1100011; t_f3 = 3'b101;
            case (i)
                0, 2: begin t_ack = 1; want = v_fetch(1); end
                1: begin t_lt = 0; want = pack(3'd2, 1, 0, 0, 0, 0, 0, 0, 0); end
                3: begin t_lt = 1; want = pack(3'd0, 1, 0, 0, 0, 0, 0, 0, 0); end
                default: want = v_fetch(0);
            endcase
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL branch c%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_load();
        logic [10:0] want;
        for (int i = 0; i < 4; i++) begin
            defaults();
            t_op = 7'b0000011;
            case (i)
                0: begin t_ack = 1; want = v_fetch(1); end
                1: want = pack(3'd0, 1, 0, 0, 1, 0, 0, 0, 0);
                2: want = pack(3'd0, 0, 0, 0, 0, 0, 1, 0, 0);
                default: want = v_fetch(0);
            endcase
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL load c%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_intr();
        logic [10:0] want;
        for (int i = 0; i < 5; i++) begin
            defaults();
            case (i)
                0: begin t_intr = 1; t_mie = 1; want = v_fetch(0); end
                1: begin t_ack = 1; want = v_fetch(1); end
                2: want = v_alu();
                3: want = v_trap_or_fetch();
                default: want = v_fetch(0);
            endcase
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL intr c%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_mret();
        logic [10:0] want;
        for (int i = 0; i < 7; i++) begin
            defaults();
            case (i)
                0: begin t_ack = 1; t_intr = 1; t_mie = 1; want = v_fetch(1); end
                1: begin
                    t_op = 7'b1110011; t_mret = 1;
                    want = INT_EN ? pack(3'd5, 1, 0, 0, 0, 0, 0, 0, 1)
                                  : pack(3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
                end
                3: begin t_ack = 1; want = v_fetch(1); end
                4: want = v_alu();
                5: want = v_trap_or_fetch();
                default: want = v_fetch(0);
            endcase
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL mret c%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_reset_in_intr();
        logic [10:0] want;
        for (int i = 0; i < 7; i++) begin
            defaults();
            case (i)
                0: begin t_ack = 1; t_intr = 1; t_mie = 1; want = v_fetch(1); end
                1: want = v_alu();
                2: begin t_rst = 0; t_ack = 1; t_intr = 1; t_mie = 1; want = 11'd0; end
                4: begin t_ack = 1; want = v_fetch(1); end
                5: want = v_alu();
                default: want = v_fetch(0);
            endcase
            step();
            checks++;
            if (obs !== want) begin
                failures++;
                $display("FAIL reset_in_intr c%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[11];
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110011,
                7'b0010011, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0000000};
        for (int i = 0; i < 800; i++) begin
            defaults();
            t_op = ops[$urandom_range(0, 10)];
            if (t_op == 7'b0000000) t_op = 7'($urandom);
            t_mret = (t_op == 7'b1110011) && ($urandom_range(0, 1) == 1);
            t_f3 = 3'($urandom);
            t_eq = 1'($urandom); t_lt = 1'($urandom); t_ltu = 1'($urandom);
            t_ack = ($urandom_range(0, 3) != 0);
            t_intr = ($urandom_range(0, 7) == 0);
            t_mie = 1'($urandom);
            t_rst = ($urandom_range(0, 60) != 0);
            step();
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random c%0d ph=%0d op=%b got=%h want=%h", i, m_ph, t_op, obs, exp_v);
            end
        end
    endtask

    initial begin
        defaults();
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_stall();
        test_decode();
        test_branch();
        test_load();
        test_intr();
        test_mret();
        test_reset_in_intr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 synchronous active-low reset.
REQ-002 The block SHALL provide opcode input 7: instruction bits [6:0] from the IR.
REQ-003 The block SHALL provide func3 input 3: instruction bits [14:12].
REQ-004 The block SHALL provide br_eq, br_lt, br_ltu inputs 1 each: branch-condition flags (rs1==rs2, signed <, unsigned <).
REQ-005 The block SHALL provide is_mret input 1: the decoded instruction is MRET.
REQ-006 The block SHALL provide imem_ack input 1: instruction memory has valid data for the current fetch.
REQ-007 The block SHALL provide intr input 1: external interrupt request (level or single-cycle pulse).
REQ-008 The block SHALL provide mie input 1: CSR global interrupt enable.
REQ-009 The block SHALL provide pc_source output 3: PC mux select (0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc).
REQ-010 The block SHALL provide pc_write output 1: PC register load enable.
REQ-011 The block SHALL provide ir_write, mem_rden1, mem_rden2, mem_we2, rf_we outputs 1 each: IR load, instruction read, data read, data write, register-file write.
REQ-012 The block SHALL provide int_taken output 1: trap entry (CSR saves mepc, clears mie).
REQ-013 The block SHALL provide mret_exec output 1: MRET retiring (CSR restores mie).

Function
REQ-014 The block SHALL be a Moore/Mealy FSM with states FETCH, EXEC, WRITEBACK and INTR.
REQ-015 In FETCH, the block SHALL hold mem_rden1=1 every cycle until imem_ack=1.
REQ-016 In the FETCH cycle with imem_ack=1, the block SHALL assert ir_write=1 and go to EXEC; with imem_ack=0 it SHALL stay in FETCH with no other strobe asserted.
REQ-017 Every EXEC SHALL last one cycle with pc_write=1.
REQ-018 In EXEC, pc_source SHALL be 3 for opcode 1101111 (JAL).
REQ-019 In EXEC, pc_source SHALL be 1 for opcode 1100111 (JALR).
REQ-020 In EXEC for opcode 1100011, pc_source SHALL be 2 when taken, else 0; taken is func3 000 br_eq, 001 !br_eq, 100 br_lt, 101 !br_lt, 110 br_ltu, 111 !br_ltu; func3 010 and 011 SHALL be not taken.
REQ-021 In EXEC with is_mret=1, pc_source SHALL be 5 and mret_exec SHALL be 1.
REQ-022 In EXEC for all other opcodes, pc_source SHALL be 0.
REQ-023 rf_we SHALL be 1 in EXEC for opcodes 0110011, 0010011, 0110111, 0010111, 1101111 and 1100111.
REQ-024 mem_we2 SHALL be 1 in EXEC for opcode 0100011 (store).
REQ-025 For opcode 0000011 (load), EXEC SHALL assert mem_rden2=1 and go to WRITEBACK; WRITEBACK SHALL assert rf_we=1 for one cycle.
REQ-026 Unknown opcodes SHALL advance the PC only (pc_source 0, no rf_we/mem strobes).
REQ-027 intr_pend register: set on any cycle with intr=1 and mie=1 (captures pulses in any state); cleared only on the INTR cycle.
REQ-028 After EXEC, or after WRITEBACK for a load, the FSM SHALL go to INTR if intr_pend is set, or if intr=1 and mie=1 in that same cycle; otherwise it SHALL go to FETCH.
REQ-029 An MRET EXEC SHALL not go to INTR even if intr_pend is set; the pending request SHALL be serviced after the next instruction.
REQ-030 INTR SHALL last one cycle: pc_source=4, pc_write=1, int_taken=1, then FETCH.
REQ-031 When mie deasserts after intr_pend is set, the pending request SHALL still be taken.
REQ-032 Outside the asserting states, every strobe SHALL be 0 and pc_source SHALL be 0.

Reset
REQ-033 rst_n=0 sampled at a clk edge SHALL force state FETCH and clear intr_pend, including mid-EXEC, WRITEBACK, INTR or a stalled fetch.
REQ-034 While rst_n=0, all outputs SHALL be 0, including pc_source=0 and mem_rden1=0.
REQ-035 In the first cycle after release, FETCH SHALL assert mem_rden1=1.

Configuration
REQ-036 Macro PC_SEQ_INTR_EN defined SHALL enable INTR, intr_pend, int_taken, mret_exec and pc_source 4/5 as above.
REQ-037 With PC_SEQ_INTR_EN undefined, there SHALL be no INTR state or intr_pend; intr and mie SHALL be ignored; int_taken and mret_exec SHALL be tied 0; MRET SHALL be treated as an unknown opcode (pc_source 0).

Verification
REQ-038 The bench SHALL check: reset, then imem_ack low for 3 cycles -> mem_rden1=1 for 4 cycles, ir_write only in the ack cycle, EXEC next.
REQ-039 The bench SHALL check: opcode 1100011, func3 101, br_lt=0 -> EXEC pc_source=2, pc_write=1; with br_lt=1 -> pc_source=0.
REQ-040 The bench SHALL check: load 0000011 -> EXEC mem_rden2=1, pc_write=1, then WRITEBACK rf_we=1, then FETCH.
REQ-041 The bench SHALL check: 1-cycle intr pulse with mie=1 during FETCH stall -> after EXEC, INTR with pc_source=4, int_taken=1, then FETCH.
REQ-042 The bench SHALL check: is_mret=1 with intr_pend set -> pc_source=5, mret_exec=1, next state FETCH; INTR after the following EXEC.
REQ-043 The bench SHALL check: rst_n=0 during INTR -> next cycle FETCH, int_taken=0, intr_pend cleared; with PC_SEQ_INTR_EN undefined, intr never yields pc_source=4.
